data_memory_seq: RTL
====================

Name: data_memory_seq

Overview:
- Parametrised successor to the 8x32 data memory: configurable data width, address width and depth.
- Registered read port with a valid strobe and a ready/busy indication.
- Clear no longer resets every word at once. It starts an init sequencer that rewrites the power-on pattern one word per cycle, so the array can map to block RAM.
- Out-of-range accesses are detected and flagged. Sits between the datapath's ALU/address stage and write-back.

Parameters:
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 8: address port width.
- DEPTH, 32: number of words. Must be even, >= 2 and <= 2**ADDR_WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-high reset; starts init sequence.
- reinit  in  1  synchronous request to rerun the init sequence without reset.
- signal_memread  in  1  read request; sampled only when ready=1.
- signal_memwrite  in  1  write request; sampled only when ready=1.
- address  in  ADDR_WIDTH  word address.
- data_to_write  in  DATA_WIDTH  write data.
- ready  out  1  high in RUN; accesses accepted.
- data_out  out  DATA_WIDTH  registered read data.
- data_valid  out  1  one-cycle strobe; data_out holds a new read result.
- addr_error  out  1  one-cycle strobe; accepted access had address >= DEPTH.

Behaviour:
- Init pattern, with H = DEPTH/2:
  - word i = i for i < H.
  - word i = -(i-H) in two's complement for i >= H, so word H = 0.
  - Values are truncated to DATA_WIDTH bits.
  - With defaults: word 17 = 0xFF, word 31 = 0xF1.
- States: INIT, RUN. Pointer init_ptr is ADDR_WIDTH bits.
- clear asserted, asynchronously:
  - state=INIT, init_ptr=0.
  - ready=0, data_out=0, data_valid=0, addr_error=0.
  - Array contents are not touched asynchronously.
- INIT, each rising edge with clear low:
  - mem[init_ptr] <= pattern(init_ptr); init_ptr++.
  - The edge that writes word DEPTH-1 also sets state=RUN and ready=1.
  - Total: exactly DEPTH edges after clear deasserts before ready=1.
- INIT ignores signal_memread, signal_memwrite and address:
  - no array write from ports.
  - data_valid=0, addr_error=0.
- reinit:
  - In RUN: next edge goes to INIT with init_ptr=0 and ready=0; no access is performed on that edge.
  - In INIT: restarts init_ptr at 0.
  - data_out holds its value in both cases.
- RUN access, on each edge:
  - Read, in range: data_out <= mem[address] (value before any same-edge write); data_valid=1 the following cycle.
  - Write, in range: mem[address] <= data_to_write.
  - Read and write together, same address: both performed. data_out returns the OLD word (read-before-write); the new word is visible on the next read.
  - Address >= DEPTH: write suppressed; read gives data_out <= 0 with data_valid=1. addr_error=1 for one cycle whenever read or write is requested.
  - No request: data_valid=0, addr_error=0, data_out holds.
- Latency:
  - Read data appears one cycle after the request edge.
  - Back-to-back reads are allowed every cycle.
  - A write is visible to a read issued on the next edge.
- clear mid-operation (any state, including mid-INIT): immediately back to the clear state. A partially completed init sequence restarts from word 0.
- Words DEPTH..2**ADDR_WIDTH-1 do not exist; no aliasing or wrap-around of addresses.

Test Plan:
- Pulse clear, release, count edges: ready rises after exactly 32 edges. Then read addresses 0,15,16,17,31 -> data_out 0x00,0x0F,0x00,0xFF,0xF1, each with data_valid one cycle after request.
- Write 0xA5 to address 5; read 5 on the next edge -> 0xA5. Read 6 -> 0x06.
- Read and write address 3 with data 0x77 on the same edge -> data_out 0x03. Next read of 3 -> 0x77.
- Access address 40, write 0x55 then read -> addr_error pulses on both. Read returns 0x00 with data_valid=1. Reads of 0..31 unchanged.
- Assert clear at init_ptr=10 (mid-INIT), release -> 32 further edges to ready. Requests during INIT produce no data_valid and do not modify memory.
- In RUN, overwrite word 20 with 0x00, pulse reinit -> ready drops for 32 cycles. Word 20 reads 0xFC afterwards; data_out retained its prior value throughout.

Source files
------------

// File: rtl/data_memory_seq.sv
// Parametrised data memory with a registered read port and an init sequencer
// that rewrites the power-on pattern one word per cycle after clear or reinit.
module data_memory_seq #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 32
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  reinit,
   input  logic                  signal_memread,
   input  logic                  signal_memwrite,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_to_write,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  addr_error
);

   localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                    HALF      = DEPTH / 2;
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] HALF_A    = ADDR_WIDTH'(HALF);
   localparam logic [DATA_WIDTH-1:0] HALF_D    = DATA_WIDTH'(HALF);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   init_ptr;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    in_range;
   logic [IDX_W-1:0]        acc_idx;
   logic                    mem_we;
   logic [IDX_W-1:0]        mem_waddr;
   logic [DATA_WIDTH-1:0]   mem_wdata;

   // Upper half counts down from zero: H - i equals -(i-H) modulo 2**DATA_WIDTH.
   function automatic logic [DATA_WIDTH-1:0] init_pattern(input logic [ADDR_WIDTH-1:0] idx);
      logic [DATA_WIDTH-1:0] idx_d;
      idx_d = DATA_WIDTH'(idx);
      if (idx < HALF_A) return idx_d;
      return HALF_D - idx_d;
   endfunction

   assign in_range = {1'b0, address} < DEPTH_EXT;
   assign acc_idx  = address[IDX_W-1:0];

   // Single write port shared by the sequencer and the access path.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (!clear) begin
         if (state == S_INIT && !reinit) begin
            mem_we    = 1'b1;
            mem_waddr = init_ptr[IDX_W-1:0];
            mem_wdata = init_pattern(init_ptr);
         end else if (state == S_RUN && !reinit && signal_memwrite && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = acc_idx;
            mem_wdata = data_to_write;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state      <= S_INIT;
         init_ptr   <= '0;
         ready      <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         addr_error <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         addr_error <= 1'b0;
         case (state)
            S_INIT: begin
               if (reinit) begin
                  init_ptr <= '0;
               end else if (init_ptr == LAST_PTR) begin
                  state    <= S_RUN;
                  ready    <= 1'b1;
                  init_ptr <= '0;
               end else begin
                  init_ptr <= init_ptr + ADDR_WIDTH'(1);
               end
            end
            S_RUN: begin
               if (reinit) begin
                  state    <= S_INIT;
                  ready    <= 1'b0;
                  init_ptr <= '0;
               end else begin
                  // mem read here sees the pre-edge word, giving read-before-write.
                  if (signal_memread) begin
                     data_valid <= 1'b1;
                     data_out   <= in_range ? mem[acc_idx] : '0;
                  end
                  addr_error <= (signal_memread | signal_memwrite) & ~in_range;
               end
            end
            default: begin
               state <= S_INIT;
               ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
